msi_cpu_cache_controller: RTL and testbench
===========================================

// Module: msi_cpu_cache_controller
// PURPOSE
//   CPU-side controller for one direct-mapped MSI snoopy cache unit. Sequences the tag/state/data arrays
//   on CPU read/write requests and runs bus transactions: victim write-back, line fill, and invalidate.
//   Sits between the CPU, the cache unit's CPU port and the shared-bus arbiter.
//   The snoopy controller drives the cache unit's second port independently.
// PARAMETERS
//   ADDRESS_WIDTH  16      CPU/bus address width = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
//   DATA_WIDTH     16      word width
//   TAG_WIDTH      8       tag field, address[AW-1 -: TAG_WIDTH]
//   INDEX_WIDTH    6       line index field
//   OFFSET_WIDTH   2       word-in-line field; words per line WPL = 2**OFFSET_WIDTH
//   (state encoding fixed: INVALID=2'b00, SHARED=2'b01, MODIFIED=2'b10)
// PORTS
//   clock              in   1    single clock, all flops on rising edge
//   reset              in   1    asynchronous, active-low
//   cpu_address        in   AW   request address, held until cpu_function_complete
//   cpu_data_in        in   DW   write data
//   cpu_read/cpu_write in   1    request strobes, held until complete; both high = read
//   cpu_data_out       out  DW   read data, valid with cpu_function_complete
//   cpu_function_complete out 1  one-cycle completion pulse
//   cache_tag_in/cache_index/cache_offset out TAG/IDX/OFF  cache unit CPU-port address
//   cache_data_in      out  DW   data to write into the cache array
//   cache_state_in     out  2    state to write
//   cache_write_tag/cache_write_state/cache_write_data out 1  write enables
//   cache_hit          in   1    tag match and state != INVALID
//   cache_tag_out/cache_state_out/cache_data_out in TAG/2/DW  contents at the addressed index/offset
//   bus_request        out  1    to arbiter; high from leaving IDLE until return to IDLE
//   bus_grant          in   1    arbiter grant; held while bus_request is high
//   bus_address        out  AW   transaction address
//   bus_data_out       out  DW   write-back data
//   bus_data_in        in   DW   fill data, valid with bus_function_complete
//   bus_read/bus_read_exclusive/bus_invalidate/bus_write out 1  command, one-hot, only while granted
//   bus_function_complete in 1   per-word (or per-invalidate) acknowledge pulse
// BEHAVIOUR
//   - Reset: FSM=IDLE, word counter=0; all outputs 0 except address/data passthroughs.
//     Reset asserted mid-transaction aborts immediately with no cache writes.
//   - FSM states: IDLE, WAIT_GRANT, WRITEBACK, FILL, INVALIDATE.
//   - Cache index/tag are always taken from cpu_address. cache_offset = cpu offset in IDLE, word counter elsewhere.
//   - IDLE, read hit: in the same cycle, cpu_function_complete=1 and cpu_data_out=cache_data_out (0-wait).
//   - IDLE, write hit on MODIFIED: same cycle, write_data=1 and complete=1.
//   - IDLE, write hit on SHARED, or any miss: go to WAIT_GRANT and raise bus_request.
//   - WAIT_GRANT: on bus_grant, re-evaluate the line, because a snoop may have changed it:
//     * hit on SHARED with a write -> INVALIDATE;
//     * miss with victim MODIFIED -> WRITEBACK;
//     * otherwise miss -> FILL;
//     * now a hit on a serviceable access -> IDLE (bus released).
//   - WRITEBACK: bus_write with bus_address={cache_tag_out,index,counter} and bus_data_out=cache_data_out.
//     Each bus_function_complete increments the counter. After word WPL-1 the counter wraps to 0 -> FILL.
//   - FILL: bus_read for a CPU read, bus_read_exclusive for a write; bus_address={cpu tag,index,counter}.
//     On each complete: write_data=1 with bus_data_in at the counter offset, and the counter increments.
//     On the last word, also write_tag=1 and write_state=SHARED (read) or MODIFIED (write), then go IDLE.
//   - INVALIDATE: bus_invalidate with line address; on complete write_state=MODIFIED -> IDLE.
//   - Back in IDLE the still-held request hits and completes. Minimum miss latency = grant wait + WPL bus words + 1.
//   - Bus commands are asserted only while bus_grant=1; the controller never drops bus_request mid-line.
// TESTING
//   - Read miss, INVALID line, WPL=4: grant and 4 completes with data 0x11..0x44.
//     -> 4 data writes, tag written, state SHARED, CPU gets 0x11 at offset 0 one cycle after the last complete.
//   - Read hit at offset 2 -> complete the same cycle, cpu_data_out=0x33, no bus_request.
//   - Write 0xBEEF to a SHARED line -> one bus_invalidate, state MODIFIED, data written, complete.
//   - Miss on a MODIFIED victim with tag 0x5A -> 4 bus_writes at {0x5A,idx,0..3}, then a fill.
//     The fill uses bus_read_exclusive for a write.
//   - A snoop invalidates the SHARED line while in WAIT_GRANT on a write.
//     -> after grant, FILL with bus_read_exclusive, not INVALIDATE.
//   - Reset pulsed low during FILL word 2 -> outputs 0, IDLE, no tag/state write, counter 0.

Source files
------------

// File: rtl/msi_cpu_cache_controller.sv
// CPU-side controller for one direct-mapped MSI snoopy cache: serves hits in place and
// runs victim write-back, line fill and invalidate transactions on the shared bus.
module msi_cpu_cache_controller #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int TAG_WIDTH     = 8,
  parameter int INDEX_WIDTH   = 6,
  parameter int OFFSET_WIDTH  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address_i,
  input  logic [DATA_WIDTH-1:0]    cpu_data_in_i,
  input  logic                     cpu_read_i,
  input  logic                     cpu_write_i,
  output logic [DATA_WIDTH-1:0]    cpu_data_out_o,
  output logic                     cpu_function_complete_o,
  output logic [TAG_WIDTH-1:0]     cache_tag_in_o,
  output logic [INDEX_WIDTH-1:0]   cache_index_o,
  output logic [OFFSET_WIDTH-1:0]  cache_offset_o,
  output logic [DATA_WIDTH-1:0]    cache_data_in_o,
  output logic [1:0]               cache_state_in_o,
  output logic                     cache_write_tag_o,
  output logic                     cache_write_state_o,
  output logic                     cache_write_data_o,
  input  logic                     cache_hit_i,
  input  logic [TAG_WIDTH-1:0]     cache_tag_out_i,
  input  logic [1:0]               cache_state_out_i,
  input  logic [DATA_WIDTH-1:0]    cache_data_out_i,
  output logic                     bus_request_o,
  input  logic                     bus_grant_i,
  output logic [ADDRESS_WIDTH-1:0] bus_address_o,
  output logic [DATA_WIDTH-1:0]    bus_data_out_o,
  input  logic [DATA_WIDTH-1:0]    bus_data_in_i,
  output logic                     bus_read_o,
  output logic                     bus_read_exclusive_o,
  output logic                     bus_invalidate_o,
  output logic                     bus_write_o,
  input  logic                     bus_function_complete_i
);

  typedef enum logic [1:0] {
    LINE_INVALID  = 2'b00,
    LINE_SHARED   = 2'b01,
    LINE_MODIFIED = 2'b10
  } line_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_WRITEBACK,
    S_FILL,
    S_INVALIDATE
  } ctrl_state_e;

  ctrl_state_e              state_q, state_d;
  logic [OFFSET_WIDTH-1:0]  cnt_q, cnt_d;
  logic                     bus_req_q;

  logic [TAG_WIDTH-1:0]     cpu_tag;
  logic [INDEX_WIDTH-1:0]   cpu_index;
  logic [OFFSET_WIDTH-1:0]  cpu_offset;
  logic                     req;
  logic                     is_write;
  logic                     line_modified;
  logic                     line_shared;
  logic                     last_word;
  logic                     ack;

  assign cpu_tag       = cpu_address_i[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign cpu_index     = cpu_address_i[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_offset    = cpu_address_i[OFFSET_WIDTH-1:0];
  assign req           = cpu_read_i | cpu_write_i;
  // Both strobes high is treated as a read.
  assign is_write      = cpu_write_i & ~cpu_read_i;
  assign line_modified = (cache_state_out_i == LINE_MODIFIED);
  assign line_shared   = (cache_state_out_i == LINE_SHARED);
  assign last_word     = (cnt_q == '1);
  assign ack           = bus_grant_i & bus_function_complete_i;

  assign cache_tag_in_o = cpu_tag;
  assign cache_index_o  = cpu_index;
  assign cpu_data_out_o = cache_data_out_i;
  assign bus_data_out_o = cache_data_out_i;
  assign bus_request_o  = bus_req_q;

  always_comb begin
    state_d                 = state_q;
    cnt_d                   = cnt_q;
    cpu_function_complete_o = 1'b0;
    cache_offset_o          = cnt_q;
    cache_data_in_o         = cpu_data_in_i;
    cache_state_in_o        = LINE_INVALID;
    cache_write_tag_o       = 1'b0;
    cache_write_state_o     = 1'b0;
    cache_write_data_o      = 1'b0;
    bus_address_o           = {cpu_tag, cpu_index, cnt_q};
    bus_read_o              = 1'b0;
    bus_read_exclusive_o    = 1'b0;
    bus_invalidate_o        = 1'b0;
    bus_write_o             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cache_offset_o = cpu_offset;
        if (req) begin
          if (cache_hit_i && !is_write) begin
            cpu_function_complete_o = 1'b1;
          end else if (cache_hit_i && line_modified) begin
            cache_write_data_o      = 1'b1;
            cpu_function_complete_o = 1'b1;
          end else begin
            state_d = S_WAIT_GRANT;
            cnt_d   = '0;
          end
        end
      end

      // The line is re-examined after grant since a snoop may have changed it meanwhile.
      S_WAIT_GRANT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (bus_grant_i) begin
          if (cache_hit_i) begin
            state_d = (is_write && line_shared) ? S_INVALIDATE : S_IDLE;
          end else if (line_modified) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_WRITEBACK: begin
        bus_address_o = {cache_tag_out_i, cpu_index, cnt_q};
        bus_write_o   = bus_grant_i;
        if (ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        bus_read_o           = bus_grant_i & ~is_write;
        bus_read_exclusive_o = bus_grant_i & is_write;
        cache_data_in_o      = bus_data_in_i;
        if (ack) begin
          cache_write_data_o = 1'b1;
          cnt_d              = cnt_q + 1'b1;
          if (last_word) begin
            cache_write_tag_o   = 1'b1;
            cache_write_state_o = 1'b1;
            cache_state_in_o    = is_write ? LINE_MODIFIED : LINE_SHARED;
            state_d             = S_IDLE;
          end
        end
      end

      S_INVALIDATE: begin
        bus_address_o    = {cpu_tag, cpu_index, {OFFSET_WIDTH{1'b0}}};
        bus_invalidate_o = bus_grant_i;
        if (ack) begin
          cache_write_state_o = 1'b1;
          cache_state_in_o    = LINE_MODIFIED;
          state_d             = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // While reset is held no strobe may reach the cache or the bus.
    if (!rst_ni) begin
      cpu_function_complete_o = 1'b0;
      cache_write_tag_o       = 1'b0;
      cache_write_state_o     = 1'b0;
      cache_write_data_o      = 1'b0;
      bus_read_o              = 1'b0;
      bus_read_exclusive_o    = 1'b0;
      bus_invalidate_o        = 1'b0;
      bus_write_o             = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_req_q <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_msi_cpu_cache_controller.sv
// Bench for msi_cpu_cache_controller: cache-array, arbiter and memory models around the DUT,
// with a line-level MSI reference model predicting bus traffic and CPU-visible data.
module tb_msi_cpu_cache_controller;
  localparam int AW = 16, DW = 16, TW = 8, IW = 6, OW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_data_in, cpu_data_out;
  logic          cpu_read, cpu_write, cpu_function_complete;
  logic [TW-1:0] cache_tag_in, cache_tag_out;
  logic [IW-1:0] cache_index;
  logic [OW-1:0] cache_offset;
  logic [DW-1:0] cache_data_in, cache_data_out;
  logic [1:0]    cache_state_in, cache_state_out;
  logic          cache_write_tag, cache_write_state, cache_write_data, cache_hit;
  logic          bus_request, bus_grant;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_data_out, bus_data_in;
  logic          bus_read, bus_read_exclusive, bus_invalidate, bus_write, bus_complete;

  msi_cpu_cache_controller #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_address_i(cpu_address), .cpu_data_in_i(cpu_data_in),
    .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_data_out_o(cpu_data_out), .cpu_function_complete_o(cpu_function_complete),
    .cache_tag_in_o(cache_tag_in), .cache_index_o(cache_index), .cache_offset_o(cache_offset),
    .cache_data_in_o(cache_data_in), .cache_state_in_o(cache_state_in),
    .cache_write_tag_o(cache_write_tag), .cache_write_state_o(cache_write_state),
    .cache_write_data_o(cache_write_data), .cache_hit_i(cache_hit),
    .cache_tag_out_i(cache_tag_out), .cache_state_out_i(cache_state_out),
    .cache_data_out_i(cache_data_out),
    .bus_request_o(bus_request), .bus_grant_i(bus_grant), .bus_address_o(bus_address),
    .bus_data_out_o(bus_data_out), .bus_data_in_i(bus_data_in),
    .bus_read_o(bus_read), .bus_read_exclusive_o(bus_read_exclusive),
    .bus_invalidate_o(bus_invalidate), .bus_write_o(bus_write),
    .bus_function_complete_i(bus_complete)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    logic [15:0] w;
    w = {14'd0, a[1:0]} + 16'd1;
    return (w * 16'h0011) ^ (a & 16'hFFFC);
  endfunction

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Cache unit arrays (CPU port) with a snoop-side invalidate hook.
  logic [TW-1:0] c_tag  [64];
  logic [1:0]    c_st   [64];
  logic [DW-1:0] c_data [64][4];
  bit            c_init;
  logic          snoop_en;
  logic [IW-1:0] snoop_idx;

  always @(posedge clk) begin
    if (!c_init) begin
      for (int i = 0; i < 64; i++) begin
        c_tag[i] <= '0;
        c_st[i]  <= '0;
        for (int j = 0; j < 4; j++) c_data[i][j] <= '0;
      end
      c_init <= 1'b1;
    end else begin
      if (cache_write_data)  c_data[cache_index][cache_offset] <= cache_data_in;
      if (cache_write_tag)   c_tag[cache_index] <= cache_tag_in;
      if (cache_write_state) c_st[cache_index]  <= cache_state_in;
      if (snoop_en)          c_st[snoop_idx]    <= 2'b00;
    end
  end

  always_comb begin
    cache_tag_out   = c_tag[cache_index];
    cache_state_out = c_st[cache_index];
    cache_data_out  = c_data[cache_index][cache_offset];
    cache_hit       = (c_st[cache_index] != 2'b00) && (c_tag[cache_index] == cache_tag_in);
  end

  // Arbiter: grant after grant_delay cycles of request, held until request drops.
  int grant_delay, gcnt;
  always @(posedge clk) begin
    if (!rst_n || !bus_request) begin
      bus_grant <= 1'b0;
      gcnt      <= 0;
    end else if (!bus_grant) begin
      if (gcnt >= grant_delay) bus_grant <= 1'b1;
      else gcnt <= gcnt + 1;
    end
  end

  // Memory + bus responder; every acknowledged command is logged.
  logic [DW-1:0] mem [65536];
  bit            m_init;
  int            resp_delay, rcnt, log_n, viol;
  logic [15:0]   log_addr [4096];
  logic [2:0]    log_kind [4096];
  logic [15:0]   log_data [4096];
  int            log_cyc  [4096];
  logic [3:0]    cmd;
  assign cmd = {bus_read, bus_read_exclusive, bus_write, bus_invalidate};

  always @(posedge clk) begin
    if (!m_init) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_val(16'(a));
      m_init       <= 1'b1;
      bus_complete <= 1'b0;
      bus_data_in  <= '0;
      rcnt         <= 0;
    end else begin
      bus_complete <= 1'b0;
      if (cmd != 4'd0 && (!bus_grant || $countones(cmd) != 1)) viol <= viol + 1;
      if (!rst_n || cmd == 4'd0 || bus_complete) begin
        rcnt <= 0;
      end else if (rcnt >= resp_delay) begin
        rcnt         <= 0;
        bus_complete <= 1'b1;
        log_addr[log_n] <= bus_address;
        log_kind[log_n] <= bus_read ? 3'd1 : bus_read_exclusive ? 3'd2 : bus_write ? 3'd3 : 3'd4;
        log_data[log_n] <= bus_write ? bus_data_out : mem[bus_address];
        log_cyc[log_n]  <= cyc;
        log_n           <= log_n + 1;
        if (bus_write) mem[bus_address] <= bus_data_out;
        else bus_data_in <= mem[bus_address];
      end else begin
        rcnt <= rcnt + 1;
      end
    end
  end

  // Reference model: CPU-visible memory image and per-line tag/MSI state.
  logic [15:0] golden [65536];
  logic [7:0]  m_tag  [64];
  int          m_st   [64];
  int          total, bad;
  logic [15:0] last_rdata;
  int          last_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input bit wr, input bit both, input logic [15:0] a,
                        input logic [15:0] d, input bit snoop, input string nm);
    logic [7:0]  tg;
    logic [5:0]  ix;
    bit          hit, e_inv, e_wb, e_fill, got;
    int          ne, s, vs, n, dcyc;
    logic [2:0]  ek [10];
    logic [15:0] ea [10];
    logic [15:0] ed [10];
    logic        req_done;
    tg = a[15:8];
    ix = a[7:2];
    if (snoop) m_st[ix] = 0;
    hit    = (m_st[ix] != 0) && (m_tag[ix] == tg);
    e_inv  = wr && hit && (m_st[ix] == 1);
    e_wb   = !hit && (m_st[ix] == 2);
    e_fill = !hit;
    ne = 0;
    if (e_wb)
      for (int w = 0; w < 4; w++) begin
        ea[ne] = {m_tag[ix], ix, 2'(w)}; ek[ne] = 3'd3; ed[ne] = golden[ea[ne]]; ne++;
      end
    if (e_fill)
      for (int w = 0; w < 4; w++) begin
        ea[ne] = {tg, ix, 2'(w)}; ek[ne] = wr ? 3'd2 : 3'd1; ed[ne] = '0; ne++;
      end
    if (e_inv) begin
      ea[ne] = {tg, ix, 2'b00}; ek[ne] = 3'd4; ed[ne] = '0; ne++;
    end
    s = log_n; vs = viol; got = 0; n = 0;

    @(posedge clk); #1;
    cpu_address = a; cpu_data_in = d;
    cpu_read = !wr; cpu_write = wr | both;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      snoop_en  = snoop && (k == 1);
      snoop_idx = ix;
      if (snoop && k == 1) chk({nm, "_snoop_in_wait"}, {30'd0, bus_request, bus_grant}, 32'd2);
      if (cpu_function_complete) begin got = 1; n = k; break; end
    end
    snoop_en   = 1'b0;
    last_rdata = cpu_data_out;
    last_lat   = n;
    dcyc       = cyc;
    req_done   = bus_request;
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;

    chk({nm, "_complete"}, 32'(got), 32'd1);
    if (!wr) chk({nm, "_rdata"}, 32'(last_rdata), 32'(golden[a]));
    if (hit && !e_inv) chk({nm, "_zero_wait"}, 32'(n), 32'd0);
    else if (log_n > s) chk({nm, "_done_after_last_ack"}, 32'(dcyc), 32'(log_cyc[log_n-1] + 2));
    chk({nm, "_req_low_at_done"}, 32'(req_done), 32'd0);
    chk({nm, "_bus_ops"}, 32'(log_n - s), 32'(ne));
    for (int i = 0; i < ne && s + i < log_n; i++) begin
      chk({nm, "_kind"}, 32'(log_kind[s+i]), 32'(ek[i]));
      chk({nm, "_addr"}, 32'(log_addr[s+i]), 32'(ea[i]));
      if (ek[i] == 3'd3) chk({nm, "_wb_data"}, 32'(log_data[s+i]), 32'(ed[i]));
    end
    chk({nm, "_cmd_protocol"}, 32'(viol), 32'(vs));

    if (!hit) begin
      m_tag[ix] = tg;
      m_st[ix]  = wr ? 2 : 1;
    end else if (wr) begin
      m_st[ix] = 2;
    end
    if (wr) golden[a] = d;
  endtask

  initial begin
    int s0;
    bit seen;
    for (int a = 0; a < 65536; a++) golden[a] = init_val(16'(a));
    for (int i = 0; i < 64; i++) begin m_tag[i] = '0; m_st[i] = 0; end
    rst_n = 1'b0;
    cpu_address = '0; cpu_data_in = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    snoop_en = 1'b0; snoop_idx = '0;
    grant_delay = 1; resp_delay = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'd0, bus_request, bus_read, bus_read_exclusive, bus_write,
        bus_invalidate, cache_write_tag, cache_write_state, cache_write_data,
        cpu_function_complete}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read miss on an INVALID line, memory words 0x11..0x44.
    cpu_op(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, "read_miss");
    chk("read_miss_data", 32'(last_rdata), 32'h0011);
    chk("read_miss_state", 32'(c_st[0]), 32'd1);
    chk("read_miss_tag", 32'(c_tag[0]), 32'd0);
    for (int w = 0; w < 4; w++) chk("read_miss_line", 32'(c_data[0][w]), 32'((w + 1) * 16'h11));

    cpu_op(1'b0, 1'b0, 16'h0002, 16'h0, 1'b0, "read_hit");
    chk("read_hit_data", 32'(last_rdata), 32'h0033);
    chk("read_hit_lat", 32'(last_lat), 32'd0);

    cpu_op(1'b1, 1'b0, 16'h0001, 16'hBEEF, 1'b0, "write_shared");
    chk("write_shared_state", 32'(c_st[0]), 32'd2);
    chk("write_shared_word", 32'(c_data[0][1]), 32'hBEEF);
    cpu_op(1'b0, 1'b0, 16'h0001, 16'h0, 1'b0, "readback");

    // MODIFIED victim with tag 0x5A at index 5, then evicted by a write.
    cpu_op(1'b1, 1'b0, 16'h5A15, 16'h1234, 1'b0, "make_dirty");
    cpu_op(1'b1, 1'b0, 16'h3316, 16'hCAFE, 1'b0, "evict_write");
    cpu_op(1'b0, 1'b0, 16'h5A15, 16'h0, 1'b0, "evict_read");
    chk("evict_read_data", 32'(last_rdata), 32'h1234);

    // Snoop invalidates the SHARED line while the write waits for grant.
    cpu_op(1'b0, 1'b0, 16'h1024, 16'h0, 1'b0, "snoop_prep");
    grant_delay = 6;
    cpu_op(1'b1, 1'b0, 16'h1025, 16'h7777, 1'b1, "snoop_write");
    grant_delay = 1;

    // Reset mid-fill: after words 0 and 1, while the counter points at word 2.
    resp_delay = 1;
    s0 = log_n;
    seen = 0;
    @(posedge clk); #1;
    cpu_address = 16'h2031; cpu_read = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (log_n - s0 == 2) begin seen = 1; break; end
    end
    chk("reset_fill_reached_word2", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {23'd0, bus_request, bus_read, bus_read_exclusive, bus_write,
        bus_invalidate, cache_write_tag, cache_write_state, cache_write_data,
        cpu_function_complete}, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_mid_state", 32'(c_st[12]), 32'd0);
    chk("reset_mid_tag", 32'(c_tag[12]), 32'd0);
    cpu_read = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_mid_idle", 32'(bus_request), 32'd0);
    resp_delay = 0;
    cpu_op(1'b0, 1'b0, 16'h2031, 16'h0, 1'b0, "after_reset");

    // Random traffic over a few conflicting tags and indexes.
    for (int t = 0; t < 150; t++) begin
      logic [7:0]  rt;
      logic [5:0]  ri;
      bit          rw;
      bit          rb;
      rt = ($urandom_range(0, 3) == 0) ? 8'h00 : ($urandom_range(0, 1) == 0) ? 8'h5A : 8'hC1;
      ri = 6'($urandom_range(0, 3) * 4 + 1);
      rw = 1'($urandom_range(0, 1));
      rb = !rw && ($urandom_range(0, 7) == 0);
      grant_delay = $urandom_range(0, 3);
      resp_delay  = $urandom_range(0, 2);
      cpu_op(rw, rb, {rt, ri, 2'($urandom_range(0, 3))}, 16'($urandom), 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
